// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg: shared state enum, word/count widths and pad word constant for pad_ctrl
package pad_ctrl_pkg;
  localparam int WORD_W = 64;
  localparam int CNT_W = 58;
  localparam logic [WORD_W-1:0] PAD_WORD = {1'b1, {(WORD_W-1){1'b0}}};
  typedef enum logic [1:0] {MSG, PAD, ZERO, LEN} state_t;
endpackage

// File: rtl/pad_word_cnt.sv
// pad_word_cnt: block word index and message word count with increment/clear controls
module pad_word_cnt
  import pad_ctrl_pkg::*;
#(
  parameter int BLK_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inc_idx,
  input  logic                         inc_cnt,
  input  logic                         clr,
  output logic [$clog2(BLK_WORDS)-1:0] idx,
  output logic [CNT_W-1:0]             cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      cnt <= '0;
    end else if (clr) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      if (inc_idx) idx <= idx + 1'b1;
      if (inc_cnt) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pad_ctrl.sv
// pad_ctrl: message padding controller driving an external word mux (pad, zeros, length word).
// Define PAD_CTRL_BLK_END_EN to add the blk_end output flagging the last word of each block.
module pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int BLK_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              pad_pkt,
  output logic              zero_pkt,
  output logic              mgln_pkt,
  output logic [WORD_W-1:0] msg_len
`ifdef PAD_CTRL_BLK_END_EN
  ,
  output logic              blk_end
`endif
);
  localparam int IW = $clog2(BLK_WORDS);
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic xfer, pre_last;
  assign xfer = out_valid && out_ready;
  // next index lands on the last block slot, so the length word goes there
  assign pre_last = idx == IW'(BLK_WORDS - 2);
  assign in_ready = !rst && state == MSG && out_ready;
  assign out_valid = !rst && (state == MSG ? in_valid : 1'b1);
  assign pad_pkt = state == PAD;
  assign zero_pkt = state == ZERO;
  assign mgln_pkt = state == LEN;
  assign msg_len = {cnt, 6'b0};
`ifdef PAD_CTRL_BLK_END_EN
  assign blk_end = out_valid && idx == IW'(BLK_WORDS - 1);
`endif
  pad_word_cnt #(.BLK_WORDS(BLK_WORDS)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc_idx(xfer && state != LEN),
    .inc_cnt(xfer && state == MSG),
    .clr(xfer && state == LEN),
    .idx(idx),
    .cnt(cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= MSG;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (xfer)
      case (state)
        MSG:     nxt = in_last ? PAD : MSG;
        PAD:     nxt = pre_last ? LEN : ZERO;
        ZERO:    nxt = pre_last ? LEN : ZERO;
        default: nxt = MSG;
      endcase
  end
endmodule
